mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

MEM-stage data-memory access controller for the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It decodes the load/store ALU op carried into MEM, issues a single request on the request/acknowledge data bus, and raises a stall request until the bus acknowledges. Load results are aligned and extended before being passed toward writeback. All non-memory fields pass straight through to writeback.

## Interface
Parameters: none (widths from define.v: `RegBus` = 32, `RegAddrBus` = 5, `AluOpBus` = 8).
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  6  pipeline stall vector; bit 3 = MEM stage held
- mem_wd / mem_wreg / mem_wdata  in  5/1/32  destination register, write enable, ALU result from EX/MEM
- mem_whilo / mem_hi / mem_lo  in  1/32/32  HI/LO write from EX/MEM
- mem_aluop  in  8  operation (`EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP`, `EXE_SW_OP`, others = non-memory)
- mem_mem_addr  in  32  byte address
- mem_reg2  in  32  store source operand
- wd_o / wreg_o / wdata_o  out  5/1/32  to MEM/WB
- whilo_o / hi_o / lo_o  out  1/32/32  to MEM/WB (pass-through)
- stallreq_o  out  1  MEM stall request to the stall controller
- bus_req_o  out  1  request valid (registered)
- bus_we_o  out  1  1 = store (registered)
- bus_addr_o  out  32  word address, low 2 bits forced to 00 (registered)
- bus_sel_o  out  4  byte lanes, bit 3 = bits 31:24 (registered)
- bus_wdata_o  out  32  store data (registered)
- bus_ack_i  in  1  request complete; valid only while bus_req_o = 1
- bus_rdata_i  in  32  read data, valid with bus_ack_i

## Operation
- Big-endian byte order: byte offset 00 maps to bits 31:24, offset 11 to bits 7:0.
- Byte select:
  - B ops: 00→1000, 01→0100, 10→0010, 11→0001.
  - H ops: addr[1] = 0 → 1100, addr[1] = 1 → 0011; addr[0] is ignored.
  - W ops: 1111; addr[1:0] are ignored.
  - No misalignment exception is raised.
- Store data: SB = {4{reg2[7:0]}}, SH = {2{reg2[15:0]}}, SW = reg2.
- Load data is taken from the selected lanes. LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits.
- wd_o, wreg_o, whilo_o, hi_o, lo_o always equal their inputs. wdata_o equals mem_wdata except for loads (see below).
- FSM states:
  - IDLE: if mem_aluop is a memory op and stall[3] = NoStop, register bus_req_o = 1 with we/addr/sel/wdata and go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold every bus output stable. When bus_ack_i = 1, latch the aligned load data, clear bus_req_o, then go to IDLE if stall[3] = NoStop, else go to HOLD.
  - HOLD: no request is issued. Stay until stall[3] = NoStop, then go to IDLE.
- stallreq_o (combinational) = (IDLE & memory op) | (BUSY & ~bus_ack_i).
- Load wdata_o source:
  - BUSY with ack: aligned bus_rdata_i.
  - HOLD: latched value.
  - Otherwise: don't-care, and the instruction is stalled.
- Non-memory ops never touch the bus and never request a stall.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE; bus_req_o, bus_we_o = 0; bus_addr_o, bus_sel_o, bus_wdata_o = 0; load latch = 0. stallreq_o and pass-through outputs follow the combinational rules above.
- Reset mid-transfer: bus_req_o drops without waiting for a clock edge. The outstanding transfer is abandoned, and any later ack is ignored.
- Minimum memory op: cycle 0 in IDLE (stallreq_o = 1); bus_req_o rises at edge 1; ack in cycle 1 gives stallreq_o = 0, and the result leaves at edge 2. This is one stall cycle.
- Each extra ack-wait cycle adds exactly one stall cycle.
- Exactly one request per instruction. HOLD prevents reissue while a downstream stall keeps the instruction resident.
- bus_ack_i while bus_req_o = 0 is ignored.
- Simultaneous ack and stall[3] = Stop: data is latched, the request ends, and the FSM enters HOLD.

## Test plan
- LW at 0x0000_0100, ack one cycle after req with rdata 0x1234_5678 → bus_addr 0x100, sel 1111, we 0; stallreq high for exactly 1 cycle; wdata_o = 0x1234_5678.
- LB at 0x103, rdata 0x0000_00F0 → sel 0001, wdata_o = 0xFFFF_FFF0. LBU at the same address → 0x0000_00F0. LH at 0x102, rdata 0x0000_8001 → 0xFFFF_8001.
- SH at 0x2 with reg2 0xABCD_1234 → sel 0011, wdata 0x1234_1234, we 1. SB at 0x1 with reg2 0x55 → sel 0100, wdata 0x5555_5555.
- LW with ack delayed 3 cycles and stall[3] held 2 cycles after ack → bus_req stays stable until ack; state HOLD; no second req; wdata_o stays at the acked data until release.
- rst pulled low in BUSY → bus_req_o = 0 immediately. An ack applied after reset release is ignored.
- ADD op (non-memory) → no req, stallreq_o = 0, all outputs equal inputs in the same cycle.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_pkg / mem_bus_ctrl
//
// MEM-stage data-memory access controller. Decodes the load/store op held in
// the EX/MEM register, issues exactly one request per memory instruction on a
// request/acknowledge bus, and stalls the pipeline until the bus answers.
// Loads are aligned (big-endian lanes) and sign/zero extended before being
// forwarded to MEM/WB; everything else passes straight through.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   stall[5:0]          pipeline stall vector, bit 3 holds the MEM stage
//   mem_*               EX/MEM fields (dest reg, write enables, data, HI/LO,
//                       ALU op, byte address, store operand)
//   wd_o..lo_o          MEM/WB fields
//   stallreq_o          MEM stall request (combinational)
//   bus_req_o..wdata_o  registered bus request: valid, write, word address,
//                       byte lanes (bit 3 = bits 31:24), store data
//   bus_ack_i           transfer done, meaningful only while bus_req_o = 1
//   bus_rdata_i         read data, valid with bus_ack_i
// ---------------------------------------------------------------------------
package mem_bus_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;

  localparam logic NO_STOP = 1'b0;
  localparam logic STOP    = 1'b1;

  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_e;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

endpackage

module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  // Only the MEM-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // -------------------------------------------------------------------------
  // Op decode
  // -------------------------------------------------------------------------
  size_e size;
  logic  is_store;
  logic  is_signed;
  logic  is_mem;
  logic  is_load;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    size      = SZ_NONE;
    is_store  = 1'b0;
    is_signed = 1'b0;
    case (mem_aluop)
      EXE_LB_OP:  begin size = SZ_B; is_signed = 1'b1; end
      EXE_LBU_OP: size = SZ_B;
      EXE_LH_OP:  begin size = SZ_H; is_signed = 1'b1; end
      EXE_LHU_OP: size = SZ_H;
      EXE_LW_OP:  size = SZ_W;
      EXE_SB_OP:  begin size = SZ_B; is_store = 1'b1; end
      EXE_SH_OP:  begin size = SZ_H; is_store = 1'b1; end
      EXE_SW_OP:  begin size = SZ_W; is_store = 1'b1; end
      default:    ;
    endcase
  end

  assign is_mem  = (size != SZ_NONE);
  assign is_load = is_mem & ~is_store;

  // -------------------------------------------------------------------------
  // Lane select and store data (big-endian: offset 00 is bits 31:24)
  // -------------------------------------------------------------------------
  logic [3:0]  lane_sel;
  logic [31:0] store_data;

  always_comb begin
    lane_sel   = 4'b0000;
    store_data = mem_reg2;
    case (size)
      SZ_B: begin
        case (mem_mem_addr[1:0])
          2'b00:   lane_sel = 4'b1000;
          2'b01:   lane_sel = 4'b0100;
          2'b10:   lane_sel = 4'b0010;
          default: lane_sel = 4'b0001;
        endcase
        store_data = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        // addr[0] is ignored: misaligned halves silently round down.
        lane_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
        store_data = {2{mem_reg2[15:0]}};
      end
      SZ_W:    lane_sel = 4'b1111;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Load alignment from the live read data
  // -------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    case (mem_mem_addr[1:0])
      2'b00:   rd_byte = bus_rdata_i[31:24];
      2'b01:   rd_byte = bus_rdata_i[23:16];
      2'b10:   rd_byte = bus_rdata_i[15:8];
      default: rd_byte = bus_rdata_i[7:0];
    endcase
    rd_half = mem_mem_addr[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (size)
      SZ_B:    load_data = {{24{is_signed & rd_byte[7]}}, rd_byte};
      SZ_H:    load_data = {{16{is_signed & rd_half[15]}}, rd_half};
      default: load_data = bus_rdata_i;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (is_mem && stall[3] == NO_STOP) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_mem_addr[31:2], 2'b00};
          sel_d   = lane_sel;
          wdata_d = store_data;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          load_d  = load_data;
          req_d   = 1'b0;
          // A downstream stall parks the finished instruction in HOLD so the
          // still-resident memory op cannot trigger a second request.
          state_d = (stall[3] == NO_STOP) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (stall[3] == NO_STOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the load latch is a single register, not a memory array, so it is
  // cleared on reset along with the bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = wdata_q;

  assign stallreq_o = ((state_q == IDLE) & is_mem) |
                      ((state_q == BUSY) & ~bus_ack_i);

  assign wd_o    = mem_wd;
  assign wreg_o  = mem_wreg;
  assign whilo_o = mem_whilo;
  assign hi_o    = mem_hi;
  assign lo_o    = mem_lo;

  // Outside the ack cycle and HOLD the load result is unused (the stage is
  // stalled), so the live aligned data is forwarded there as well.
  assign wdata_o = !is_load           ? mem_wdata :
                   (state_q == HOLD)  ? load_q    : load_data;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam logic [5:0] STALL_MEM = 6'b001111;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (arithmetic over bytes) --------------
  function automatic int m_bytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit m_store(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic bit m_signed(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LH_OP;
  endfunction

  // Offset of the first accessed byte, rounded down to the access size.
  function automatic int m_off(input logic [7:0] op, input logic [31:0] a);
    int n = m_bytes(op);
    int o = int'(a[1:0]);
    return (n == 0) ? 0 : (o / n) * n;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    int n = m_bytes(op);
    int mask = ((1 << n) - 1) << (4 - n - m_off(op, a));
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_sdata(input logic [7:0] op, input logic [31:0] r);
    case (m_bytes(op))
      1:       return {24'b0, r[7:0]} * 32'h0101_0101;
      2:       return {16'b0, r[15:0]} * 32'h0001_0001;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n = m_bytes(op);
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v = ({32'b0, rd} >> (8 * (4 - n - m_off(op, a)))) & mask;
    if (m_signed(op) && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- per-cycle expectations set by the driver ---------------
  bit          chk_en    = 1'b0;
  bit          exp_req   = 1'b0;
  bit          exp_stall = 1'b0;
  bit          exp_wvalid = 1'b0;
  logic [31:0] exp_rdata = '0;

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("wd_o", 32'(wd_o), 32'(mem_wd));
      check("wreg_o", 32'(wreg_o), 32'(mem_wreg));
      check("whilo_o", 32'(whilo_o), 32'(mem_whilo));
      check("hi_o", hi_o, mem_hi);
      check("lo_o", lo_o, mem_lo);
      check("bus_req_o", 32'(bus_req_o), 32'(exp_req));
      check("stallreq_o", 32'(stallreq_o), 32'(exp_stall));
      if (exp_req) begin
        check("bus_addr_o", bus_addr_o, mem_mem_addr & 32'hFFFF_FFFC);
        check("bus_sel_o", 32'(bus_sel_o), 32'(m_sel(mem_aluop, mem_mem_addr)));
        check("bus_we_o", 32'(bus_we_o), 32'(m_store(mem_aluop)));
        if (m_store(mem_aluop))
          check("bus_wdata_o", bus_wdata_o, m_sdata(mem_aluop, mem_reg2));
      end
      if (m_bytes(mem_aluop) == 0 || m_store(mem_aluop))
        check("wdata_o_pass", wdata_o, mem_wdata);
      else if (exp_wvalid)
        check("wdata_o_load", wdata_o, m_load(mem_aluop, mem_mem_addr, exp_rdata));
    end
  end

  // ---------------- directed transaction driver ----------------------------
  int seq = 0;

  task automatic set_fields(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
    seq++;
    mem_aluop    = op;
    mem_mem_addr = a;
    mem_reg2     = r2;
    mem_wd       = 5'(seq * 7);
    mem_wreg     = seq[0];
    mem_whilo    = seq[1];
    mem_wdata    = 32'hA5A5_0000 + 32'(seq);
    mem_hi       = 32'h1100_0000 + 32'(seq);
    mem_lo       = 32'h2200_0000 + 32'(seq);
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] rd, input int pre_stop, input int ack_dly,
                       input int hold, output logic [31:0] got_w, output logic [31:0] got_hw,
                       output logic [3:0] got_sel, output logic [31:0] got_bw,
                       output int n_stall);
    bit mem = (m_bytes(op) != 0);
    bit ld  = mem && !m_store(op);
    n_stall = 0; got_w = '0; got_hw = '0; got_sel = '0; got_bw = '0;
    // Held in IDLE by a downstream stall: stall requested, nothing issued.
    for (int i = 0; i < pre_stop; i++) begin
      @(posedge clk); #1;
      set_fields(op, a, r2); stall = STALL_MEM; bus_ack_i = 1'b0;
      exp_req = 1'b0; exp_stall = mem; exp_wvalid = 1'b0;
      @(negedge clk); n_stall += int'(stallreq_o);
    end
    @(posedge clk); #1;
    if (pre_stop == 0) set_fields(op, a, r2);
    stall = 6'b0; bus_ack_i = 1'b0;
    exp_req = 1'b0; exp_stall = mem; exp_wvalid = 1'b0;
    @(negedge clk); n_stall += int'(stallreq_o);
    if (mem) begin
      for (int k = 0; k < ack_dly; k++) begin
        @(posedge clk); #1;
        exp_req = 1'b1; exp_stall = 1'b1;
        @(negedge clk); n_stall += int'(stallreq_o);
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b1; bus_rdata_i = rd; exp_rdata = rd;
      stall = (hold > 0) ? STALL_MEM : 6'b0;
      exp_req = 1'b1; exp_stall = 1'b0; exp_wvalid = ld;
      @(negedge clk); n_stall += int'(stallreq_o);
      got_w = wdata_o; got_sel = bus_sel_o; got_bw = bus_wdata_o;
      for (int j = 1; j <= hold; j++) begin
        @(posedge clk); #1;
        // A stray ack and changed read data must both be ignored in HOLD.
        bus_ack_i = (j == 1); bus_rdata_i = ~rd;
        stall = (j < hold) ? STALL_MEM : 6'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_wvalid = ld;
        @(negedge clk); n_stall += int'(stallreq_o);
        got_hw = wdata_o;
      end
    end
    @(posedge clk); #1;
    set_fields(EXE_ADD_OP, 32'h0, 32'h0);
    bus_ack_i = 1'b0; stall = 6'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_wvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w, hw, bw;
    logic [3:0]  sel;
    int          ns;

    rst = 1'b0; stall = 6'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    set_fields(EXE_ADD_OP, 32'h0, 32'h0);
    #12;
    check("rst_bus_req", 32'(bus_req_o), 32'h0);
    check("rst_bus_we", 32'(bus_we_o), 32'h0);
    check("rst_bus_addr", bus_addr_o, 32'h0);
    check("rst_bus_sel", 32'(bus_sel_o), 32'h0);
    check("rst_bus_wdata", bus_wdata_o, 32'h0);
    check("rst_stallreq", 32'(stallreq_o), 32'h0);
    check("rst_wdata_pass", wdata_o, mem_wdata);
    #1 rst = 1'b1; chk_en = 1'b1;

    do_op(EXE_LW_OP, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0, 0, w, hw, sel, bw, ns);
    check("lw_wdata", w, 32'h1234_5678);
    check("lw_sel", 32'(sel), 32'hF);
    check("lw_stall_cycles", 32'(ns), 32'd1);

    do_op(EXE_LB_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0, 0, w, hw, sel, bw, ns);
    check("lb_wdata", w, 32'hFFFF_FFF0);
    check("lb_sel", 32'(sel), 32'h1);

    do_op(EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0, 0, w, hw, sel, bw, ns);
    check("lbu_wdata", w, 32'h0000_00F0);

    do_op(EXE_LH_OP, 32'h0000_0102, 32'h0, 32'h0000_8001, 0, 0, 0, w, hw, sel, bw, ns);
    check("lh_wdata", w, 32'hFFFF_8001);

    do_op(EXE_LHU_OP, 32'h0000_0101, 32'h0, 32'h8001_7F00, 0, 1, 0, w, hw, sel, bw, ns);
    check("lhu_wdata", w, 32'h0000_8001);
    check("lhu_sel", 32'(sel), 32'hC);
    check("lhu_stall_cycles", 32'(ns), 32'd2);

    do_op(EXE_LB_OP, 32'h0000_0200, 32'h0, 32'h7F80_0000, 0, 0, 0, w, hw, sel, bw, ns);
    check("lb0_wdata", w, 32'h0000_007F);

    do_op(EXE_SH_OP, 32'h0000_0002, 32'hABCD_1234, 32'h0, 0, 0, 0, w, hw, sel, bw, ns);
    check("sh_sel", 32'(sel), 32'h3);
    check("sh_bus_wdata", bw, 32'h1234_1234);

    do_op(EXE_SB_OP, 32'h0000_0001, 32'h0000_0055, 32'h0, 0, 0, 1, w, hw, sel, bw, ns);
    check("sb_sel", 32'(sel), 32'h4);
    check("sb_bus_wdata", bw, 32'h5555_5555);

    do_op(EXE_SW_OP, 32'h0000_0107, 32'hCAFE_F00D, 32'h0, 2, 0, 0, w, hw, sel, bw, ns);
    check("sw_bus_wdata", bw, 32'hCAFE_F00D);
    check("sw_stall_cycles", 32'(ns), 32'd3);

    do_op(EXE_LW_OP, 32'h0000_0300, 32'h0, 32'h89AB_CDEF, 0, 3, 2, w, hw, sel, bw, ns);
    check("lw_hold_ack_wdata", w, 32'h89AB_CDEF);
    check("lw_hold_last_wdata", hw, 32'h89AB_CDEF);
    check("lw_hold_stall_cycles", 32'(ns), 32'd4);

    do_op(EXE_ADD_OP, 32'h0000_0100, 32'h1, 32'h0, 0, 0, 0, w, hw, sel, bw, ns);
    check("add_stall_cycles", 32'(ns), 32'd0);

    // Reset in the middle of a transfer.
    @(posedge clk); #1;
    set_fields(EXE_LW_OP, 32'h0000_0400, 32'h0);
    exp_req = 1'b0; exp_stall = 1'b1; exp_wvalid = 1'b0;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_stall = 1'b1;
    check("busy_before_rst", 32'(bus_req_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus_req_o), 32'h0);
    check("rst_mid_addr", bus_addr_o, 32'h0);
    set_fields(EXE_ADD_OP, 32'h0, 32'h0);
    exp_req = 1'b0; exp_stall = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    check("post_rst_req", 32'(bus_req_o), 32'h0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
